// File: rtl/nvdla_sdp_wdma_pkg.sv
// Shared types and helpers for the SDP WDMA write sequencer.
// The line_beats helper operates on DW_DEF-bit fields.
package nvdla_sdp_wdma_pkg;

    localparam int DW_DEF = 13;
    localparam int AW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wdma_state_e;

    // In 8-bit mode two atoms share one beat, so the line is half as long.
    function automatic logic [DW_DEF-1:0] line_beats(input logic dp_8,
                                                     input logic [DW_DEF-1:0] width);
        logic [DW_DEF-1:0] atoms;
        atoms = dp_8 ? (width >> 1) : width;
        return atoms + DW_DEF'(1);
    endfunction

endpackage

// File: rtl/nvdla_sdp_wdma_seq_addr_gen.sv
// Line/surface walker: produces the start address of each line of the cube.
module nvdla_sdp_wdma_seq_addr_gen
    import nvdla_sdp_wdma_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          load,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] line_stride,
    input  logic [AW-1:0] surf_stride,
    input  logic [DW-1:0] height,
    input  logic [DW-1:0] surf_num,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [AW-1:0] line_stride_q;
    logic [AW-1:0] surf_stride_q;
    logic [DW-1:0] height_q;
    logic [DW-1:0] surf_num_q;
    logic [DW-1:0] line_cnt;
    logic [DW-1:0] surf_cnt;
    logic [AW-1:0] line_addr;
    logic [AW-1:0] surf_addr;

    // Stepping past the last line of a surface restarts from the next surface base.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            line_stride_q <= '0;
            surf_stride_q <= '0;
            height_q      <= '0;
            surf_num_q    <= '0;
            line_cnt      <= '0;
            surf_cnt      <= '0;
            line_addr     <= '0;
            surf_addr     <= '0;
        end else if (load) begin
            line_stride_q <= line_stride;
            surf_stride_q <= surf_stride;
            height_q      <= height;
            surf_num_q    <= surf_num;
            line_cnt      <= '0;
            surf_cnt      <= '0;
            line_addr     <= base_addr;
            surf_addr     <= base_addr;
        end else if (step) begin
            if (line_cnt == height_q) begin
                line_cnt  <= '0;
                surf_cnt  <= surf_cnt + DW'(1);
                surf_addr <= surf_addr + surf_stride_q;
                line_addr <= surf_addr + surf_stride_q;
            end else begin
                line_cnt  <= line_cnt + DW'(1);
                line_addr <= line_addr + line_stride_q;
            end
        end
    end

    assign addr = line_addr;
    assign last = (line_cnt == height_q) && (surf_cnt == surf_num_q);

endmodule

// File: rtl/nvdla_sdp_wdma_seq.sv
// SDP WDMA write sequencer: per-line write commands, credit-limited against
// the beats drained by the unpack stage, with a completion pulse.
module nvdla_sdp_wdma_seq
    import nvdla_sdp_wdma_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MAX_OUT = 4
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          op_en,
    input  logic          cfg_dp_8,
    input  logic [AW-1:0] cfg_dst_base_addr,
    input  logic [AW-1:0] cfg_dst_line_stride,
    input  logic [AW-1:0] cfg_dst_surface_stride,
    input  logic [DW-1:0] cfg_width,
    input  logic [DW-1:0] cfg_height,
    input  logic [DW-1:0] cfg_surf_num,
    output logic          cmd_pvld,
    input  logic          cmd_prdy,
    output logic [AW-1:0] cmd_addr,
    output logic [DW-1:0] cmd_size,
    output logic          cmd_last,
    input  logic          dat_pvld,
    input  logic          dat_prdy,
    output logic          op_done,
    output logic          busy
);

    localparam int OUT_W = 4;

    wdma_state_e      state;
    wdma_state_e      state_nxt;
    logic [DW-1:0]    width_q;
    logic             dp8_q;
    logic [DW-1:0]    beat_cnt;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outstanding_nxt;
    logic             op_done_q;
    logic             load;
    logic             cmd_accept;
    logic             addr_last;
    logic             beat_fire;
    logic             line_done;
    logic             final_line;

    assign load       = (state == IDLE) && op_en;
    assign cmd_pvld   = (state == RUN) && (outstanding < OUT_W'(MAX_OUT));
    assign cmd_accept = cmd_pvld && cmd_prdy;
    assign cmd_last   = (state == RUN) && addr_last;
    assign cmd_size   = DW'(line_beats(dp8_q, DW_DEF'(width_q)) - DW_DEF'(1));
    assign beat_fire  = dat_pvld && dat_prdy && (state != IDLE);
    assign line_done  = beat_fire && (beat_cnt == cmd_size);
    // Once every command is out, the last outstanding line is the final one.
    assign final_line = (state == DRAIN) && line_done && (outstanding == OUT_W'(1));
    assign busy       = (state != IDLE);
    assign op_done    = op_done_q;

    nvdla_sdp_wdma_seq_addr_gen #(
        .AW (AW),
        .DW (DW)
    ) u_addr_gen (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .load            (load),
        .base_addr       (cfg_dst_base_addr),
        .line_stride     (cfg_dst_line_stride),
        .surf_stride     (cfg_dst_surface_stride),
        .height          (cfg_height),
        .surf_num        (cfg_surf_num),
        .step            (cmd_accept),
        .addr            (cmd_addr),
        .last            (addr_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_en) state_nxt = RUN;
            RUN:     if (cmd_accept && addr_last) state_nxt = DRAIN;
            DRAIN:   if (final_line) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A completion with no line outstanding is illegal; saturate rather than wrap.
    always_comb begin
        outstanding_nxt = outstanding;
        if (cmd_accept && !line_done) begin
            outstanding_nxt = outstanding + OUT_W'(1);
        end else if (!cmd_accept && line_done && (outstanding != '0)) begin
            outstanding_nxt = outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state       <= IDLE;
            width_q     <= '0;
            dp8_q       <= 1'b0;
            beat_cnt    <= '0;
            outstanding <= '0;
            op_done_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_done_q <= final_line;
            if (load) begin
                width_q     <= cfg_width;
                dp8_q       <= cfg_dp_8;
                beat_cnt    <= '0;
                outstanding <= '0;
            end else begin
                outstanding <= outstanding_nxt;
                if (beat_fire) begin
                    beat_cnt <= line_done ? '0 : beat_cnt + DW'(1);
                end
            end
        end
    end

    credit_underflow_a: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        line_done |-> (outstanding != '0));

endmodule

// File: tb/tb_nvdla_sdp_wdma_seq.sv
// Self-checking bench for nvdla_sdp_wdma_seq: directed and random cubes
// compared against a line-list reference model built from plain arithmetic.
module tb_nvdla_sdp_wdma_seq;

    localparam int AW      = 32;
    localparam int DW      = 13;
    localparam int MAX_OUT = 4;

    logic          nvdla_core_clk = 1'b0;
    logic          nvdla_core_rstn;
    logic          op_en;
    logic          cfg_dp_8;
    logic [AW-1:0] cfg_dst_base_addr;
    logic [AW-1:0] cfg_dst_line_stride;
    logic [AW-1:0] cfg_dst_surface_stride;
    logic [DW-1:0] cfg_width;
    logic [DW-1:0] cfg_height;
    logic [DW-1:0] cfg_surf_num;
    logic          cmd_pvld;
    logic          cmd_prdy;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_size;
    logic          cmd_last;
    logic          dat_pvld;
    logic          dat_prdy;
    logic          op_done;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    nvdla_sdp_wdma_seq #(
        .AW      (AW),
        .DW      (DW),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .nvdla_core_clk         (nvdla_core_clk),
        .nvdla_core_rstn        (nvdla_core_rstn),
        .op_en                  (op_en),
        .cfg_dp_8               (cfg_dp_8),
        .cfg_dst_base_addr      (cfg_dst_base_addr),
        .cfg_dst_line_stride    (cfg_dst_line_stride),
        .cfg_dst_surface_stride (cfg_dst_surface_stride),
        .cfg_width              (cfg_width),
        .cfg_height             (cfg_height),
        .cfg_surf_num           (cfg_surf_num),
        .cmd_pvld               (cmd_pvld),
        .cmd_prdy               (cmd_prdy),
        .cmd_addr               (cmd_addr),
        .cmd_size               (cmd_size),
        .cmd_last               (cmd_last),
        .dat_pvld               (dat_pvld),
        .dat_prdy               (dat_prdy),
        .op_done                (op_done),
        .busy                   (busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] ls,
                                 input logic [31:0] ss, input int w, input int h,
                                 input int s, input logic dp8);
        cfg_dst_base_addr      = base;
        cfg_dst_line_stride    = ls;
        cfg_dst_surface_stride = ss;
        cfg_width              = DW'(w);
        cfg_height             = DW'(h);
        cfg_surf_num           = DW'(s);
        cfg_dp_8               = dp8;
        op_en                  = 1'b1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_pvld"}, cmd_pvld, 0);
        checkOutput({tag, "_last"}, cmd_last, 0);
        checkOutput({tag, "_done"}, op_done, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // One cube: launch, then per cycle compare against the expected line list
    // and the credit window; optionally abort with reset after abort_beats beats.
    task automatic runCube(input logic [31:0] base, input logic [31:0] ls,
                           input logic [31:0] ss, input int w, input int h, input int s,
                           input logic dp8, input int prdy_pct, input int dat_pct,
                           input int hold_cycles, input int abort_beats);
        logic [31:0] exp_addr [$];
        int   total, bpl, acc, beats, lines_done, credit_cap;
        logic exp_pvld, exp_done, accept, fire, finished;

        bpl   = dp8 ? (w / 2 + 1) : (w + 1);
        total = (h + 1) * (s + 1);
        credit_cap = (total < MAX_OUT) ? total : MAX_OUT;
        for (int si = 0; si <= s; si++) begin
            for (int li = 0; li <= h; li++) begin
                exp_addr.push_back(base + 32'(si) * ss + 32'(li) * ls);
            end
        end

        applyStimulus(base, ls, ss, w, h, s, dp8);
        @(negedge nvdla_core_clk);
        op_en = 1'b0;
        checkOutput("busy_launch", busy, 1);
        cfg_dst_base_addr      = $urandom;
        cfg_dst_line_stride    = $urandom;
        cfg_dst_surface_stride = $urandom;
        cfg_width              = DW'($urandom);
        cfg_height             = DW'($urandom);
        cfg_surf_num           = DW'($urandom);
        cfg_dp_8               = 1'($urandom);

        acc = 0;
        beats = 0;
        exp_done = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            lines_done = beats / bpl;
            exp_pvld = (acc < total) && ((acc - lines_done) < MAX_OUT);
            checkOutput("op_done", op_done, exp_done);
            checkOutput("busy", busy, !exp_done);
            if (exp_done) begin
                finished = 1'b1;
                break;
            end
            checkOutput("cmd_pvld", cmd_pvld, exp_pvld);
            if (exp_pvld) begin
                checkOutput("cmd_addr", cmd_addr, exp_addr[acc]);
                checkOutput("cmd_size", cmd_size, bpl - 1);
                checkOutput("cmd_last", cmd_last, acc == total - 1);
            end
            if (hold_cycles > 0 && cyc == hold_cycles - 1) begin
                checkOutput("credit_limit", acc, credit_cap);
            end
            if (abort_beats > 0 && beats >= abort_beats) break;
            cmd_prdy = ($urandom_range(99) < prdy_pct);
            dat_pvld = (acc * bpl > beats) && (cyc >= hold_cycles) &&
                       ($urandom_range(99) < dat_pct);
            dat_prdy = ($urandom_range(99) < dat_pct);
            accept = exp_pvld && cmd_prdy;
            fire   = dat_pvld && dat_prdy;
            @(posedge nvdla_core_clk);
            if (accept) acc++;
            if (fire) begin
                beats++;
                if (beats == total * bpl) exp_done = 1'b1;
            end
            @(negedge nvdla_core_clk);
        end
        cmd_prdy = 1'b0;
        dat_pvld = 1'b0;
        dat_prdy = 1'b0;

        if (abort_beats > 0) begin
            #2 nvdla_core_rstn = 1'b0;
            #1;
            checkIdleOutputs("abort");
            checkOutput("abort_addr", cmd_addr, 0);
            checkOutput("abort_size", cmd_size, 0);
            repeat (2) @(negedge nvdla_core_clk);
            nvdla_core_rstn = 1'b1;
            repeat (4) begin
                @(negedge nvdla_core_clk);
                checkOutput("abort_no_done", op_done, 0);
                checkOutput("abort_idle", busy, 0);
            end
        end else begin
            checkOutput("cube_finished", finished, 1);
            @(negedge nvdla_core_clk);
            checkIdleOutputs("after_done");
        end
    endtask

    initial begin
        nvdla_core_rstn = 1'b0;
        op_en    = 1'b0;
        cmd_prdy = 1'b0;
        dat_pvld = 1'b0;
        dat_prdy = 1'b0;
        applyStimulus(32'h0, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        op_en = 1'b0;
        #1;
        checkIdleOutputs("reset");
        checkOutput("reset_addr", cmd_addr, 0);
        repeat (2) @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        @(negedge nvdla_core_clk);

        $display("[TB] basic cube");
        runCube(32'h1000, 32'h100, 32'h1000, 3, 1, 1, 1'b0, 100, 100, 0, 0);
        $display("[TB] dp_8 mode");
        runCube(32'h4000, 32'h80, 32'h800, 7, 2, 0, 1'b1, 100, 100, 0, 0);
        $display("[TB] credit stall");
        runCube(32'h8000, 32'h40, 32'h0, 1, 7, 0, 1'b0, 100, 100, 20, 0);
        $display("[TB] backpressure");
        runCube($urandom, 32'h240, 32'h3000, 2, 3, 1, 1'b0, 40, 70, 0, 0);
        $display("[TB] degenerate cube");
        runCube(32'h20, 32'h100, 32'h1000, 0, 0, 0, 1'b0, 100, 100, 0, 0);
        $display("[TB] address wrap");
        runCube(32'hFFFF_FF00, 32'h200, 32'h1000, 1, 2, 0, 1'b0, 100, 100, 0, 0);
        $display("[TB] reset abort");
        runCube(32'hA000, 32'h100, 32'h1000, 3, 1, 1, 1'b0, 100, 100, 0, 8);
        $display("[TB] restart with new config");
        runCube(32'h5550_0000, 32'h40, 32'h400, 5, 2, 1, 1'b1, 80, 80, 0, 0);
        $display("[TB] random cubes");
        for (int n = 0; n < 6; n++) begin
            runCube($urandom, 32'($urandom_range(4095)), $urandom,
                    int'($urandom_range(5)), int'($urandom_range(3)),
                    int'($urandom_range(2)), 1'($urandom), int'($urandom_range(30, 100)),
                    int'($urandom_range(30, 100)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
